// File: rtl/cache_pkg.sv
// Shared types and sizes for the cache slave-side arbiter.
package cache_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    localparam int CACHE_ADDR_W = 30;
    localparam int CACHE_DATA_W = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// Round-robin picker: first set pend bit at or after rr_ptr, wrapping.
module cache_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(rr_ptr) + k) % N);
            if (!valid && pend[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/cache_slave_arb.sv
// Round-robin arbiter sharing one backing-memory bus among cache controllers.
// Optional WAIT-state timeout enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_slave_arb
    import cache_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = CACHE_ADDR_W,
    parameter int DATA_W      = CACHE_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      i_clk,
    input  logic                      i_nreset,
    input  logic [NUM_REQ-1:0]        i_req_sel,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    output logic [DATA_W-1:0]         o_req_rdata,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_bus_sel,
    output logic [ADDR_W-1:0]         o_bus_addr,
    input  logic [DATA_W-1:0]         i_bus_rdata,
    input  logic                      i_bus_ready,
    output logic                      o_err
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_t state, state_nxt;

    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] clr;
    logic [ADDR_W-1:0]  pend_addr [NUM_REQ];
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      owner;
    logic               pick_vld;
    logic               done;
    logic               tmo;

    cache_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .pend   (pend),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] timer;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            timer <= '0;
        end else if (state == ARB_ISSUE) begin
            timer <= '0;
        end else if (state == ARB_WAIT) begin
            timer <= timer + TW'(1);
        end
    end

    assign tmo = (state == ARB_WAIT) && !i_bus_ready
               && (timer == TW'(TIMEOUT_CYC));
`else
    logic unused_tmo;

    assign unused_tmo = |TIMEOUT_CYC;
    assign tmo        = 1'b0;
`endif

    assign done = (state == ARB_WAIT) && (i_bus_ready || tmo);
    assign clr  = done ? owner_oh : '0;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:  if (pick_vld) state_nxt = ARB_ISSUE;
            ARB_ISSUE: state_nxt = ARB_WAIT;
            ARB_WAIT:  if (done) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            owner    <= '0;
            owner_oh <= '0;
            rr_ptr   <= '0;
        end else begin
            if ((state == ARB_IDLE) && pick_vld) begin
                owner    <= pick_idx;
                owner_oh <= grant;
            end
            if (done) begin
                rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0
                                                      : owner + IW'(1);
            end
        end
    end

    // A new pulse from the requester being completed this cycle is kept.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            pend <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i_req_sel[i] && (!pend[i] || clr[i])) begin
                    pend[i]      <= 1'b1;
                    pend_addr[i] <= i_req_addr[i*ADDR_W +: ADDR_W];
                end else if (clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    assign o_bus_sel   = (state == ARB_ISSUE);
    assign o_bus_addr  = o_bus_sel ? pend_addr[owner] : '0;
    assign o_req_ready = clr;
    assign o_req_rdata = (done && i_bus_ready) ? i_bus_rdata : '0;
    assign o_err       = tmo;

    a_no_sel_while_pend : assert property (
        @(posedge i_clk) disable iff (!i_nreset)
        (i_req_sel & pend & ~clr) == '0
    ) else $error("cache_slave_arb: request while already pending");

endmodule

// File: tb/tb_cache_slave_arb.sv
// Directed bench for cache_slave_arb with bus/ready scoreboard queues.
module tb_cache_slave_arb;

    localparam int N  = 2;
    localparam int AW = 30;
    localparam int DW = 32;

    typedef struct packed {
        logic [N-1:0]  rdy;
        logic [DW-1:0] data;
    } rsp_t;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    req_sel;
    logic [N*AW-1:0] req_addr;
    logic [DW-1:0]   req_rdata;
    logic [N-1:0]    req_ready;
    logic            bus_sel;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_rdata;
    logic            bus_ready;
    logic            err;

    logic [AW-1:0] exp_bus [$];
    rsp_t          exp_rsp [$];
    rsp_t          mon_r;
    int            checks   = 0;
    int            failures = 0;
    int            n;

    always #5 clk = ~clk;

    cache_slave_arb #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk       (clk),
        .i_nreset    (nreset),
        .i_req_sel   (req_sel),
        .i_req_addr  (req_addr),
        .o_req_rdata (req_rdata),
        .o_req_ready (req_ready),
        .o_bus_sel   (bus_sel),
        .o_bus_addr  (bus_addr),
        .i_bus_rdata (bus_rdata),
        .i_bus_ready (bus_ready),
        .o_err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sel(input logic [N-1:0] s, input logic [AW-1:0] a0,
                             input logic [AW-1:0] a1);
        req_sel  = s;
        req_addr = {a1, a0};
        tick();
        req_sel  = '0;
    endtask

    task automatic wait_issue(output int cnt);
        bit found;
        found = 0;
        cnt   = 0;
        repeat (20) begin
            @(negedge clk);
            cnt++;
            if (bus_sel) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $error("FAIL wait_issue observed=no_bus_sel expected=bus_sel");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input int idx, input logic [DW-1:0] data);
        exp_rsp.push_back({N'(1) << idx, data});
        bus_ready = 1'b1;
        bus_rdata = data;
        @(negedge clk);
        chk("ready_other", 64'(req_ready[1-idx]), 0);
        tick();
        bus_ready = 1'b0;
        bus_rdata = '0;
    endtask

    // Scoreboard: every downstream issue and every completion must be expected.
    always @(negedge clk) begin
        if (bus_sel) begin
            if (exp_bus.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL bus_unexpected observed=0x%0h expected=none",
                       bus_addr);
            end else begin
                chk("bus_addr", 64'(bus_addr), 64'(exp_bus.pop_front()));
            end
        end else begin
            chk("bus_addr_idle", 64'(bus_addr), 0);
        end
        if (req_ready != '0) begin
            if (exp_rsp.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL ready_unexpected observed=0x%0h expected=none",
                       req_ready);
            end else begin
                mon_r = exp_rsp.pop_front();
                chk("ready_vec", 64'(req_ready), 64'(mon_r.rdy));
                chk("ready_rdata", 64'(req_rdata), 64'(mon_r.data));
            end
        end else begin
            chk("rdata_idle", 64'(req_rdata), 0);
        end
`ifndef CACHE_ARB_TIMEOUT_EN
        chk("err_tied", 64'(err), 0);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset    = 1'b0;
        req_sel   = '0;
        req_addr  = '0;
        bus_ready = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        tick();
        @(negedge clk);
        chk("rst_bus_sel", 64'(bus_sel), 0);
        chk("rst_bus_addr", 64'(bus_addr), 0);
        chk("rst_ready", 64'(req_ready), 0);
        chk("rst_rdata", 64'(req_rdata), 0);
        chk("rst_err", 64'(err), 0);
        tick();
        bus_ready = 1'b0;
        bus_rdata = '0;
        nreset    = 1'b1;
        tick();

        // single request, bus ready 3 cycles after issue
        exp_bus.push_back(30'h0000100);
        pulse_sel(2'b01, 30'h0000100, 30'h0);
        wait_issue(n);
        chk("lat_sel_to_bus", 64'(n), 2);
        tick();
        tick();
        respond(0, 32'hA5A5_0001);

        exp_bus.push_back(30'h0000200);
        pulse_sel(2'b10, 30'h0, 30'h0000200);
        wait_issue(n);
        respond(1, 32'h5A5A_0002);

        // simultaneous pair with rr_ptr back at 0
        exp_bus.push_back(30'h10);
        exp_bus.push_back(30'h20);
        pulse_sel(2'b11, 30'h10, 30'h20);
        wait_issue(n);
        respond(0, 32'h1111_0010);
        wait_issue(n);
        chk("pair_gap", 64'(n), 2);
        respond(1, 32'h2222_0020);

        // bus ready during ISSUE must be ignored
        exp_bus.push_back(30'h30);
        pulse_sel(2'b01, 30'h30, 30'h0);
        tick();
        bus_ready = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("issue_sel", 64'(bus_sel), 1);
        chk("issue_ready", 64'(req_ready), 0);
        tick();
        bus_ready = 1'b0;
        bus_rdata = '0;
        @(negedge clk);
        chk("wait_hold", 64'(req_ready), 0);
        tick();
        respond(0, 32'h3333_0030);

        // second pair with rr_ptr at 1: requester 1 first
        exp_bus.push_back(30'h50);
        exp_bus.push_back(30'h40);
        pulse_sel(2'b11, 30'h40, 30'h50);
        wait_issue(n);
        respond(1, 32'h4444_0050);
        wait_issue(n);
        respond(0, 32'h5555_0040);

        // request 1 arrives while 0 is in WAIT; address held
        exp_bus.push_back(30'h60);
        pulse_sel(2'b01, 30'h60, 30'h0);
        wait_issue(n);
        exp_bus.push_back(30'h20);
        pulse_sel(2'b10, 30'h60, 30'h20);
        req_addr[2*AW-1:AW] = 30'h3FF;
        tick();
        respond(0, 32'h6666_0060);
        wait_issue(n);
        chk("reissue_gap", 64'(n), 2);
        respond(1, 32'h7777_0020);

        // reset in the middle of WAIT
        exp_bus.push_back(30'h70);
        pulse_sel(2'b01, 30'h70, 30'h0);
        wait_issue(n);
        tick();
        nreset    = 1'b0;
        bus_ready = 1'b1;
        bus_rdata = 32'h0BAD_0BAD;
        #1;
        chk("mid_rst_bus_sel", 64'(bus_sel), 0);
        chk("mid_rst_addr", 64'(bus_addr), 0);
        chk("mid_rst_ready", 64'(req_ready), 0);
        chk("mid_rst_rdata", 64'(req_rdata), 0);
        chk("mid_rst_err", 64'(err), 0);
        tick();
        nreset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 0);
        tick();
        bus_ready = 1'b0;
        bus_rdata = '0;
        exp_bus.push_back(30'h80);
        pulse_sel(2'b10, 30'h0, 30'h80);
        wait_issue(n);
        chk("post_rst_lat", 64'(n), 2);
        respond(1, 32'h8888_0080);

`ifdef CACHE_ARB_TIMEOUT_EN
        exp_bus.push_back(30'h90);
        pulse_sel(2'b01, 30'h90, 30'h0);
        wait_issue(n);
        repeat (7) tick();
        @(negedge clk);
        chk("tmo_early_err", 64'(err), 0);
        chk("tmo_early_ready", 64'(req_ready), 0);
        @(posedge clk);
        #1;
        exp_rsp.push_back({2'b01, 32'h0});
        @(negedge clk);
        chk("tmo_err", 64'(err), 1);
        tick();
        exp_bus.push_back(30'hA0);
        pulse_sel(2'b10, 30'h0, 30'hA0);
        wait_issue(n);
        respond(1, 32'h9999_00A0);
`endif

        tick();
        tick();
        chk("bus_q_empty", 64'(exp_bus.size()), 0);
        chk("rsp_q_empty", 64'(exp_rsp.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
